keypad4x4_emu: RTL and testbench

- Behavioural-synthesizable keypad model: the other end of the 4x4 column-scan interface.
- Accepts a key code through a valid/ready handshake, then drives the active-low row lines in response to the scanner's active-low column strobes for a programmed hold time.
- Lets the scanner be exercised on-chip or in simulation without a physical keypad (self-test path in the MCU project).
- Optional contact bounce at press onset.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad4x4_emu_if.sv | 12 +
 rtl/keypad4x4_emu.sv | 137 +++++++++++++
 tb/tb_keypad4x4_emu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: strobe constants, FSM encoding and code-to-line mapping.
// Used by the keypad emulator and by the column scanner.
package keypad_pkg;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned LINES_N = 4;

    localparam logic [LINES_N-1:0] STROBE_IDLE = 4'b1111;
    localparam logic [LINES_N-1:0] STROBE_0    = 4'b1110;
    localparam logic [LINES_N-1:0] STROBE_1    = 4'b1101;
    localparam logic [LINES_N-1:0] STROBE_2    = 4'b1011;
    localparam logic [LINES_N-1:0] STROBE_3    = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] row_idx;
        logic [1:0] col_idx;
    } key_idx_t;

    // Upper code bits select the row, lower bits the column.
    function automatic key_idx_t key_to_idx(input logic [KEY_W-1:0] code);
        key_idx_t idx;
        idx.row_idx = code[3:2];
        idx.col_idx = code[1:0];
        return idx;
    endfunction

    function automatic logic [LINES_N-1:0] strobe(input logic [1:0] idx);
        logic [LINES_N-1:0] s;
        case (idx)
            2'd0:    s = STROBE_0;
            2'd1:    s = STROBE_1;
            2'd2:    s = STROBE_2;
            default: s = STROBE_3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/keypad4x4_emu_if.sv
// Key request handshake between a requester (master) and the keypad emulator (slave).
interface keypad4x4_emu_if;
    import keypad_pkg::*;

    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic             key_ready;

    modport master (output key_valid, output key_code, input  key_ready);
    modport slave  (input  key_valid, input  key_code, output key_ready);

endinterface

// File: rtl/keypad4x4_emu.sv
// 4x4 keypad emulator: presses a requested key for a fixed time by answering
// the scanner's active-low column strobes on the active-low row lines.
module keypad4x4_emu
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned BOUNCE_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LINES_N-1:0]  cols,
    keypad4x4_emu_if.slave      key_if,
    output logic [LINES_N-1:0]  rows,
    output logic                busy,
    output logic                done,
    output logic [7:0]          hit_cnt
);

    localparam int unsigned MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_P  = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'((BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [KEY_W-1:0]   r_code;
    logic               r_bounce_tgl;
    logic               r_key_ready;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_hit_cnt;

    logic               w_press_en;
    logic               w_accept;
    key_idx_t           w_idx;
    logic [LINES_N-1:0] w_rows;

    assign w_accept = key_if.key_valid & r_key_ready;
    assign w_idx    = key_to_idx(r_code);

    // Row drive is combinational so the scanner sees it on the edge its strobe is valid.
    always_comb begin
        w_press_en = 1'b0;
        case (r_state)
            ST_HOLD:   w_press_en = 1'b1;
            ST_BOUNCE: w_press_en = r_bounce_tgl;
            default:   w_press_en = 1'b0;
        endcase
    end

    always_comb begin
        w_rows = STROBE_IDLE;
        if (w_press_en && !cols[w_idx.col_idx]) begin
            w_rows = strobe(w_idx.row_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_code       <= '0;
            r_bounce_tgl <= 1'b1;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_hit_cnt    <= '0;
        end else begin
            r_done       <= 1'b0;
            r_bounce_tgl <= (r_state == ST_BOUNCE) ? ~r_bounce_tgl : 1'b1;

            if (w_accept) begin
                r_hit_cnt <= '0;
            end else if (w_rows != STROBE_IDLE && r_hit_cnt != 8'hFF) begin
                r_hit_cnt <= r_hit_cnt + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_code      <= key_if.key_code;
                        r_key_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (BOUNCE_CYCLES > 0) begin
                            r_state <= ST_BOUNCE;
                            r_cnt   <= BOUNCE_LOAD;
                        end else begin
                            r_state <= ST_HOLD;
                            r_cnt   <= HOLD_LOAD;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= HOLD_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_GAP;
                        r_cnt   <= GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    // Ready rises with done so a waiting request is taken back-to-back.
                    if (r_cnt == '0) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b1;
                        r_key_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rows             = w_rows;
    assign busy             = r_busy;
    assign done             = r_done;
    assign hit_cnt          = r_hit_cnt;
    assign key_if.key_ready = r_key_ready;

endmodule

// File: tb/tb_keypad4x4_emu.sv
// Directed bench for keypad4x4_emu: cycle model of timing/rows/hit count plus
// a scanner-side decoder checking reported keys against a queue of accepted codes.
module tb_keypad4x4_emu;

    localparam int H   = 16;
    localparam int G   = 8;
    localparam int TOT = H + G;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en;
    logic [1:0] scan_idx;
    logic [3:0] cols_force;
    logic [3:0] cols;
    logic [3:0] cols_b;
    logic [3:0] rows, rows_b;
    logic       busy, busy_b, done, done_b;
    logic [7:0] hit_cnt, hit_cnt_b;

    int checks = 0;
    int errors = 0;

    // Main-DUT reference model state.
    int         left;
    logic [3:0] m_code;
    int         hit_exp;
    bit         prev_low;
    bit         detected;
    int         since;
    bit         last_acc;
    int         n_acc;
    logic [3:0] exp_q[$];

    keypad4x4_emu_if kif ();
    keypad4x4_emu_if kif_b ();

    keypad4x4_emu #(.HOLD_CYCLES(16), .GAP_CYCLES(8), .BOUNCE_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .cols(cols), .key_if(kif),
        .rows(rows), .busy(busy), .done(done), .hit_cnt(hit_cnt)
    );

    keypad4x4_emu #(.HOLD_CYCLES(16), .GAP_CYCLES(8), .BOUNCE_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cols(cols_b), .key_if(kif_b),
        .rows(rows_b), .busy(busy_b), .done(done_b), .hit_cnt(hit_cnt_b)
    );

    always #5 clk = ~clk;

    // Scanner strobe: one column low per cycle, advancing on each rising edge.
    always @(posedge clk) begin
        if (scan_en) scan_idx <= scan_idx + 2'd1;
    end

    assign cols   = scan_en ? ~(4'b0001 << scan_idx) : cols_force;
    assign cols_b = 4'b1110;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        left     = 0;
        m_code   = 4'h0;
        hit_exp  = 0;
        prev_low = 1'b0;
        detected = 1'b1;
        since    = 0;
        last_acc = 1'b0;
    endtask

    // Advance one clock and check the main DUT against the model.
    task automatic step();
        logic       acc;
        logic [3:0] cap_code;
        logic [3:0] rexp;
        logic       done_exp;
        int         ri;
        int         ci;
        logic [3:0] want;
        acc      = (kif.key_valid === 1'b1) && (left == 0);
        cap_code = kif.key_code;
        @(negedge clk);
        done_exp = 1'b0;
        last_acc = acc;
        if (acc) begin
            left     = TOT;
            m_code   = cap_code;
            hit_exp  = 0;
            detected = 1'b0;
            since    = 0;
            n_acc++;
            if (scan_en || cols_force != 4'hF) exp_q.push_back(cap_code);
        end else begin
            if (prev_low && hit_exp < 255) hit_exp++;
            if (left > 0) begin
                left--;
                done_exp = (left == 0);
            end
            since++;
        end
        rexp     = (left > G && !cols[m_code[1:0]]) ? ~(4'b0001 << m_code[3:2]) : 4'hF;
        prev_low = (rexp != 4'hF);
        chk("rows", 32'(rows), 32'(rexp));
        chk("hit_cnt", 32'(hit_cnt), 32'(hit_exp));
        chk("busy", 32'(busy), 32'(left != 0));
        chk("done", 32'(done), 32'(done_exp));
        chk("key_ready", 32'(kif.key_ready), 32'(left == 0));
        // Scanner-side decode of the first row hit of each press.
        if (rows !== 4'hF && !detected) begin
            detected = 1'b1;
            ri = 0;
            ci = 0;
            for (int r = 0; r < 4; r++) if (rows[r] == 1'b0) ri = r;
            for (int c = 0; c < 4; c++) if (cols[c] == 1'b0) ci = c;
            chk("dkb_latency", 32'(since <= 4), 32'd1);
            if (exp_q.size() == 0) begin
                chk("dkb_spurious", 32'd1, 32'd0);
            end else begin
                want = exp_q.pop_front();
                chk("dkb_code", 32'({ri[1:0], ci[1:0]}), 32'(want));
            end
        end
    endtask

    initial begin
        logic [3:0] bexp;
        bit         got;
        rst_n            = 1'b0;
        scan_en          = 1'b0;
        scan_idx         = 2'd0;
        cols_force       = 4'hF;
        kif.key_valid    = 1'b0;
        kif.key_code     = 4'h0;
        kif_b.key_valid  = 1'b0;
        kif_b.key_code   = 4'h0;
        n_acc            = 0;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_rows", 32'(rows), 32'hF);
        chk("rst_ready", 32'(kif.key_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hit", 32'(hit_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // Reset in the middle of a press of key 0 with its column held low.
        cols_force    = 4'b1110;
        kif.key_valid = 1'b1;
        kif.key_code  = 4'h0;
        step();
        kif.key_valid = 1'b0;
        repeat (5) step();
        chk("midhold_rows", 32'(rows), 32'hE);
        #2 rst_n = 1'b0;
        #1 chk("async_rows", 32'(rows), 32'hF);
        chk("async_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("post_rst_hit", 32'(hit_cnt), 32'd0);
        repeat (2) step();

        // Key 4'b1111 looped back through a scanning column strobe.
        cols_force    = 4'hF;
        scan_en       = 1'b1;
        kif.key_valid = 1'b1;
        kif.key_code  = 4'hF;
        step();
        kif.key_valid = 1'b0;
        repeat (30) step();
        chk("key_f_hits", 32'(hit_cnt), 32'd4);

        // Request during HOLD is dropped.
        kif.key_valid = 1'b1;
        kif.key_code  = 4'hA;
        step();
        kif.key_valid = 1'b0;
        repeat (5) step();
        kif.key_valid = 1'b1;
        kif.key_code  = 4'h5;
        step();
        kif.key_valid = 1'b0;
        chk("ignored_acc", 32'(last_acc), 32'd0);
        repeat (30) step();
        chk("ignored_queue", 32'(exp_q.size()), 32'd0);

        // Scanner idle for a whole press.
        scan_en       = 1'b0;
        cols_force    = 4'hF;
        kif.key_valid = 1'b1;
        kif.key_code  = 4'h6;
        step();
        kif.key_valid = 1'b0;
        repeat (30) step();
        chk("idle_cols_hits", 32'(hit_cnt), 32'd0);

        // All sixteen codes back-to-back with key_valid held high.
        scan_en       = 1'b1;
        n_acc         = 0;
        kif.key_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            kif.key_code = 4'(i);
            got = 1'b0;
            for (int n = 0; n < 40 && !got; n++) begin
                step();
                got = last_acc;
            end
            chk("sweep_accept", 32'(got), 32'd1);
        end
        kif.key_valid = 1'b0;
        repeat (30) step();
        chk("sweep_count", 32'(n_acc), 32'd16);
        chk("sweep_queue", 32'(exp_q.size()), 32'd0);

        // Bounce at press onset on the second instance.
        kif_b.key_valid = 1'b1;
        kif_b.key_code  = 4'h0;
        step();
        kif_b.key_valid = 1'b0;
        for (int k = 0; k < 21; k++) begin
            if (k < 4)       bexp = (k % 2 == 0) ? 4'b1110 : 4'b1111;
            else if (k < 20) bexp = 4'b1110;
            else             bexp = 4'b1111;
            chk($sformatf("bounce_rows[%0d]", k), 32'(rows_b), 32'(bexp));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

endmodule
